// File: rtl/rotabit_pkg.sv
// Shared types and the one-hot classifier for the rotating-bit monitor.
package rotabit_pkg;

  localparam int LED_N = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_MULTI = 2'b01,
    ERR_STEP  = 2'b10,
    ERR_ZERO  = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } oh_class_t;

  typedef struct packed {
    logic [3:0] idx;
    oh_class_t  cls;
  } onehot_t;

  // Narrower buses are zero-extended by the caller; the lowest set bit wins.
  function automatic onehot_t onehot_idx(input logic [15:0] v);
    onehot_t    r;
    logic [4:0] cnt;
    r.idx = 4'd0;
    r.cls = CLS_ZERO;
    cnt   = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        r.idx = 4'(i);
        cnt   = cnt + 5'd1;
      end
    end
    if (cnt == 5'd0)      r.cls = CLS_ZERO;
    else if (cnt == 5'd1) r.cls = CLS_ONE;
    else                  r.cls = CLS_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/rotabit_monitor_sync.sv
// Two-flop synchronizer, W bits wide, synchronous active-high clear.
// Latency 2 cycles; no flow control.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rotabit_monitor.sv
// Checks a rotating one-hot LED pattern on each step edge, counts rotations, flags errors/stall.
// Latency 3 cycles from step_in pin to registered outputs; observe-only, no backpressure.
module rotabit_monitor
  import rotabit_pkg::*;
#(
  parameter int N            = LED_N,
  parameter int STALL_CYCLES = 50000000,
  parameter int WRAP_W       = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [N-1:0]      led_in,
  input  logic              step_in,
  output logic [3:0]        pos,
  output logic              pos_valid,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              stall
);

  localparam logic [3:0]  LAST_POS  = 4'(N - 1);
  localparam logic [31:0] STALL_MAX = 32'(STALL_CYCLES);

  logic [N-1:0] led_s;
  logic         step_s;
  logic         step_d;
  logic         step_ev;
  onehot_t      oh;
  logic [3:0]   next_pos;
  logic [31:0]  stall_cnt;
  mon_state_t   state;

  sync2 #(.W(N)) u_led_sync (
    .clk (CLOCK_50),
    .rst (rst),
    .d   (led_in),
    .q   (led_s)
  );

  sync2 #(.W(1)) u_step_sync (
    .clk (CLOCK_50),
    .rst (rst),
    .d   (step_in),
    .q   (step_s)
  );

  // Equal synchronizer depth keeps led_s aligned with the step edge it belongs to.
  always_ff @(posedge CLOCK_50) begin
    if (rst) step_d <= 1'b0;
    else     step_d <= step_s;
  end

  assign step_ev  = step_s & ~step_d;
  assign oh       = onehot_idx(16'(led_s));
  assign next_pos = (pos == LAST_POS) ? 4'd0 : pos + 4'd1;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= IDLE;
      pos        <= 4'd0;
      pos_valid  <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (step_ev) begin
            case (oh.cls)
              CLS_ONE: begin
                pos       <= oh.idx;
                pos_valid <= 1'b1;
                state     <= TRACK;
              end
              CLS_MULTI: begin
                err      <= 1'b1;
                err_code <= ERR_MULTI;
                state    <= FAULT;
              end
              default: ;
            endcase
          end
        end
        TRACK: begin
          if (step_ev) begin
            case (oh.cls)
              CLS_ONE: begin
                if (oh.idx == next_pos) begin
                  pos <= oh.idx;
                  if (pos == LAST_POS && !(&wrap_count))
                    wrap_count <= wrap_count + 1'b1;
                end else begin
                  pos_valid <= 1'b0;
                  err       <= 1'b1;
                  err_code  <= ERR_STEP;
                  state     <= FAULT;
                end
              end
              CLS_MULTI: begin
                pos_valid <= 1'b0;
                err       <= 1'b1;
                err_code  <= ERR_MULTI;
                state     <= FAULT;
              end
              default: begin
                pos_valid <= 1'b0;
                err       <= 1'b1;
                err_code  <= ERR_ZERO;
                state     <= FAULT;
              end
            endcase
          end
        end
        default: begin
          // Locked until reset; the first cause stays latched.
          pos_valid <= 1'b0;
          err       <= 1'b1;
        end
      endcase
    end
  end

  // A step in the threshold cycle clears the counter, so the step wins.
  always_ff @(posedge CLOCK_50) begin
    if (rst)                         stall_cnt <= 32'd0;
    else if (step_ev)                stall_cnt <= 32'd0;
    else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_rotabit_monitor.sv
// Table-driven scoreboard bench for rotabit_monitor plus stall and mid-run reset sequences.
module tb_rotabit_monitor;

  logic        clk;
  logic        rst;
  logic [9:0]  led_in;
  logic        step_in;
  logic [3:0]  pos;
  logic        pos_valid;
  logic [15:0] wrap_count;
  logic        err;
  logic [1:0]  err_code;
  logic        stall;

  rotabit_monitor #(.N(10), .STALL_CYCLES(100), .WRAP_W(16)) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .led_in     (led_in),
    .step_in    (step_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .wrap_count (wrap_count),
    .err        (err),
    .err_code   (err_code),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pos;
    logic        pv;
    logic [15:0] wrap;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    logic        rst_before;
    logic [9:0]  led;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic add(input logic rb, input logic [9:0] led, input logic [3:0] p, input logic pv,
                     input logic [15:0] w, input logic e, input logic [1:0] c);
    vec_t v;
    v.rst_before = rb;
    v.led        = led;
    v.e.pos      = p;
    v.e.pv       = pv;
    v.e.wrap     = w;
    v.e.err      = e;
    v.e.code     = c;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    step_in = 1'b0;
    led_in  = 10'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds led stable across the whole pulse; 8 cycles leaves room for the 3-cycle latency.
  task automatic step_pulse(input logic [9:0] v);
    @(negedge clk);
    led_in  = v;
    step_in = 1'b1;
    repeat (4) @(negedge clk);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: scoreboard empty, got pos=%0d, expected an entry", name, pos);
      return;
    end
    e = sb.pop_front();
    chk({name, ".pos"},       32'(pos),        32'(e.pos));
    chk({name, ".pos_valid"}, 32'(pos_valid),  32'(e.pv));
    chk({name, ".wrap"},      32'(wrap_count), 32'(e.wrap));
    chk({name, ".err"},       32'(err),        32'(e.err));
    chk({name, ".err_code"},  32'(err_code),   32'(e.code));
  endtask

  task automatic sb_step(input string name, input logic [9:0] led, input exp_t e);
    sb.push_back(e);
    step_pulse(led);
    check_pop(name);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, ".pos"},       32'(pos),        32'd0);
    chk({name, ".pos_valid"}, 32'(pos_valid),  32'd0);
    chk({name, ".wrap"},      32'(wrap_count), 32'd0);
    chk({name, ".err"},       32'(err),        32'd0);
    chk({name, ".err_code"},  32'(err_code),   32'd0);
    chk({name, ".stall"},     32'(stall),      32'd0);
  endtask

  initial begin
    exp_t e;
    rst     = 1'b1;
    step_in = 1'b0;
    led_in  = 10'd0;

    // Full rotation plus two: pos 0..9,0,1, one wrap.
    for (int i = 0; i < 12; i++)
      add(i == 0, 10'(1 << (i % 10)), 4'(i % 10), 1'b1, (i >= 10) ? 16'd1 : 16'd0, 1'b0, 2'b00);
    // All-zero samples keep IDLE, then bit0 enters TRACK.
    for (int i = 0; i < 3; i++) add(i == 0, 10'd0, 4'd0, 1'b0, 16'd0, 1'b0, 2'b00);
    add(1'b0, 10'd1, 4'd0, 1'b1, 16'd0, 1'b0, 2'b00);
    // Wrong step at pos 3, then a multi-hot sample must not overwrite the first cause.
    for (int i = 0; i < 4; i++) add(i == 0, 10'(1 << i), 4'(i), 1'b1, 16'd0, 1'b0, 2'b00);
    add(1'b0, 10'h020, 4'd3, 1'b0, 16'd0, 1'b1, 2'b10);
    add(1'b0, 10'h180, 4'd3, 1'b0, 16'd0, 1'b1, 2'b10);
    // Multi-hot at pos 6.
    for (int i = 0; i < 7; i++) add(i == 0, 10'(1 << i), 4'(i), 1'b1, 16'd0, 1'b0, 2'b00);
    add(1'b0, 10'h180, 4'd6, 1'b0, 16'd0, 1'b1, 2'b01);
    // All-zero while tracking.
    add(1'b1, 10'd1, 4'd0, 1'b1, 16'd0, 1'b0, 2'b00);
    add(1'b0, 10'd0, 4'd0, 1'b0, 16'd0, 1'b1, 2'b11);
    // Multi-hot straight out of IDLE.
    add(1'b1, 10'h003, 4'd0, 1'b0, 16'd0, 1'b1, 2'b01);

    do_reset();
    check_reset_vals("reset");

    foreach (vecs[k]) begin
      if (vecs[k].rst_before) do_reset();
      sb_step($sformatf("vec%0d", k), vecs[k].led, vecs[k].e);
    end

    // Stall threshold, saturation and clearing by a step.
    do_reset();
    repeat (99) @(negedge clk);
    chk("stall_at_99", 32'(stall), 32'd0);
    @(negedge clk);
    chk("stall_at_100", 32'(stall), 32'd1);
    repeat (20) @(negedge clk);
    chk("stall_saturated", 32'(stall), 32'd1);
    chk("stall_no_err", 32'(err), 32'd0);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_before_clear", 32'(stall), 32'd1);
    @(negedge clk);
    chk("stall_cleared", 32'(stall), 32'd0);
    chk("stall_step_tracked", 32'(pos_valid), 32'd0);
    step_in = 1'b0;
    repeat (4) @(negedge clk);

    // Five rotations, then a single-cycle reset mid-TRACK.
    do_reset();
    for (int k = 0; k < 53; k++) step_pulse(10'(1 << (k % 10)));
    chk("mid_wrap5", 32'(wrap_count), 32'd5);
    chk("mid_pos2", 32'(pos), 32'd2);
    chk("mid_valid", 32'(pos_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_reset");
    e.pos = 4'd4; e.pv = 1'b1; e.wrap = 16'd0; e.err = 1'b0; e.code = 2'b00;
    sb_step("resume", 10'h010, e);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
